// File: rtl/control_sequencer.sv
// Hard-wired Moore control unit for the single-bus DataPath: steps RESET, T0..T7, HALTED
// and decodes IR[31:27] into bus-driver, register-load, memory and ALU-op strobes.
module control_sequencer #(
    parameter int OPW             = 5,
    parameter int CNT_W           = 16,
    parameter int HALT_ON_ILLEGAL = 0
) (
    input  logic             clock,
    input  logic             clear,
    input  logic [31:0]      ir,
    output logic             PCout,
    output logic             Zhighout,
    output logic             Zlowout,
    output logic             MDRout,
    output logic             Rout,
    output logic             BAout,
    output logic             Cout,
    output logic             MARin,
    output logic             PCin,
    output logic             MDRin,
    output logic             IRin,
    output logic             Yin,
    output logic             Rin,
    output logic             ZLowIn,
    output logic             ZHighIn,
    output logic             IncPC,
    output logic             Read,
    output logic             Write,
    output logic             Gra,
    output logic             Grb,
    output logic             Grc,
    output logic [OPW-1:0]   opcode,
    output logic             run,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [3:0] S_RESET  = 4'd0;
    localparam logic [3:0] S_T0     = 4'd1;
    localparam logic [3:0] S_T1     = 4'd2;
    localparam logic [3:0] S_T2     = 4'd3;
    localparam logic [3:0] S_T3     = 4'd4;
    localparam logic [3:0] S_T4     = 4'd5;
    localparam logic [3:0] S_T5     = 4'd6;
    localparam logic [3:0] S_T6     = 4'd7;
    localparam logic [3:0] S_T7     = 4'd8;
    localparam logic [3:0] S_HALTED = 4'd9;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01011;
    localparam logic [4:0] OP_ANDI = 5'b01100;
    localparam logic [4:0] OP_ORI  = 5'b01101;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    logic [3:0]       r_state;
    logic [3:0]       w_state_next;
    logic [CNT_W-1:0] r_count;

    logic [4:0] w_op;
    logic       w_unused_ir;
    logic       w_is_rrr, w_is_imm, w_is_ldi, w_is_ld, w_is_st;
    logic       w_is_nop, w_is_halt, w_is_illegal;
    logic       w_retire;
    logic [4:0] w_imm_alu_op;

    assign w_op        = ir[31:27];
    assign w_unused_ir = ^ir[26:0];

    assign w_is_rrr  = (w_op == OP_ADD) || (w_op == OP_SUB) || (w_op == OP_AND) || (w_op == OP_OR);
    assign w_is_imm  = (w_op == OP_ADDI) || (w_op == OP_ANDI) || (w_op == OP_ORI);
    assign w_is_ldi  = (w_op == OP_LDI);
    assign w_is_ld   = (w_op == OP_LD);
    assign w_is_st   = (w_op == OP_ST);
    assign w_is_nop  = (w_op == OP_NOP);
    assign w_is_halt = (w_op == OP_HALT);
    assign w_is_illegal = !(w_is_rrr || w_is_imm || w_is_ldi || w_is_ld || w_is_st ||
                            w_is_nop || w_is_halt);

    // Immediate forms reuse the register-form ALU codes.
    assign w_imm_alu_op = (w_op == OP_ADDI) ? OP_ADD :
                          (w_op == OP_ANDI) ? OP_AND : OP_OR;

    assign w_retire = ((r_state == S_T2) && (w_is_nop || w_is_halt)) ||
                      ((r_state == S_T5) && (w_is_rrr || w_is_imm || w_is_ldi)) ||
                      (r_state == S_T7);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_RESET: w_state_next = S_T0;
            S_T0:    w_state_next = S_T1;
            S_T1:    w_state_next = S_T2;
            S_T2: begin
                if (w_is_nop)
                    w_state_next = S_T0;
                else if (w_is_halt)
                    w_state_next = S_HALTED;
                else if (w_is_illegal)
                    w_state_next = (HALT_ON_ILLEGAL != 0) ? S_HALTED : S_T0;
                else
                    w_state_next = S_T3;
            end
            S_T3:     w_state_next = S_T4;
            S_T4:     w_state_next = S_T5;
            S_T5:     w_state_next = (w_is_ld || w_is_st) ? S_T6 : S_T0;
            S_T6:     w_state_next = S_T7;
            S_T7:     w_state_next = S_T0;
            S_HALTED: w_state_next = S_HALTED;
            default:  w_state_next = S_RESET;
        endcase
    end

    // A clear on a final state wins over retirement, so the count stays at zero.
    always_ff @(posedge clock) begin
        if (clear) begin
            r_state <= S_RESET;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_retire)
                r_count <= r_count + CNT_W'(1);
        end
    end

    assign instr_count = r_count;
    assign Zhighout    = 1'b0;
    assign ZHighIn     = 1'b0;

    always_comb begin
        PCout   = 1'b0; Zlowout = 1'b0; MDRout = 1'b0; Rout  = 1'b0;
        BAout   = 1'b0; Cout    = 1'b0; MARin  = 1'b0; PCin  = 1'b0;
        MDRin   = 1'b0; IRin    = 1'b0; Yin    = 1'b0; Rin   = 1'b0;
        ZLowIn  = 1'b0; IncPC   = 1'b0; Read   = 1'b0; Write = 1'b0;
        Gra     = 1'b0; Grb     = 1'b0; Grc    = 1'b0;
        opcode  = '0;
        run     = 1'b0;
        illegal = 1'b0;
        case (r_state)
            S_T0: begin
                run = 1'b1; PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZLowIn = 1'b1;
            end
            S_T1: begin
                run = 1'b1; Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
            end
            S_T2: begin
                run = 1'b1; MDRout = 1'b1; IRin = 1'b1;
                illegal = w_is_illegal;
            end
            S_T3: begin
                run = 1'b1; Grb = 1'b1; Yin = 1'b1;
                if (w_is_rrr || w_is_imm)
                    Rout = 1'b1;
                else
                    BAout = 1'b1;
            end
            S_T4: begin
                run = 1'b1; ZLowIn = 1'b1;
                if (w_is_rrr) begin
                    Grc = 1'b1; Rout = 1'b1; opcode = OPW'(w_op);
                end else if (w_is_imm) begin
                    Cout = 1'b1; opcode = OPW'(w_imm_alu_op);
                end else begin
                    Cout = 1'b1; opcode = OPW'(OP_ADD);
                end
            end
            S_T5: begin
                run = 1'b1; Zlowout = 1'b1;
                if (w_is_ld || w_is_st)
                    MARin = 1'b1;
                else begin
                    Gra = 1'b1; Rin = 1'b1;
                end
            end
            S_T6: begin
                run = 1'b1; MDRin = 1'b1;
                if (w_is_st) begin
                    Gra = 1'b1; Rout = 1'b1;
                end else
                    Read = 1'b1;
            end
            S_T7: begin
                run = 1'b1;
                if (w_is_st)
                    Write = 1'b1;
                else begin
                    MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomised bench for control_sequencer: each instruction is checked cycle by cycle
// against a per-opcode strobe schedule built from the fetch/execute step tables.
module tb_control_sequencer;

    localparam int CW  = 8;
    localparam int HOI = 0;

    logic          clock = 1'b0;
    logic          clear = 1'b1;
    logic [31:0]   ir    = '0;
    logic PCout, Zhighout, Zlowout, MDRout, Rout, BAout, Cout;
    logic MARin, PCin, MDRin, IRin, Yin, Rin, ZLowIn, ZHighIn;
    logic IncPC, Read, Write, Gra, Grb, Grc, run, illegal;
    logic [4:0]    opcode;
    logic [CW-1:0] instr_count;

    control_sequencer #(.OPW(5), .CNT_W(CW), .HALT_ON_ILLEGAL(HOI)) dut (
        .clock(clock), .clear(clear), .ir(ir),
        .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
        .Rout(Rout), .BAout(BAout), .Cout(Cout),
        .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
        .Rin(Rin), .ZLowIn(ZLowIn), .ZHighIn(ZHighIn),
        .IncPC(IncPC), .Read(Read), .Write(Write),
        .Gra(Gra), .Grb(Grb), .Grc(Grc),
        .opcode(opcode), .run(run), .illegal(illegal), .instr_count(instr_count)
    );

    always #5 clock = ~clock;

    localparam logic [22:0] B_ILL  = 23'd1 << 0;
    localparam logic [22:0] B_RUN  = 23'd1 << 1;
    localparam logic [22:0] B_GRC  = 23'd1 << 2;
    localparam logic [22:0] B_GRB  = 23'd1 << 3;
    localparam logic [22:0] B_GRA  = 23'd1 << 4;
    localparam logic [22:0] B_WR   = 23'd1 << 5;
    localparam logic [22:0] B_RD   = 23'd1 << 6;
    localparam logic [22:0] B_INC  = 23'd1 << 7;
    localparam logic [22:0] B_ZLI  = 23'd1 << 9;
    localparam logic [22:0] B_RIN  = 23'd1 << 10;
    localparam logic [22:0] B_YIN  = 23'd1 << 11;
    localparam logic [22:0] B_IRIN = 23'd1 << 12;
    localparam logic [22:0] B_MDRI = 23'd1 << 13;
    localparam logic [22:0] B_PCIN = 23'd1 << 14;
    localparam logic [22:0] B_MARI = 23'd1 << 15;
    localparam logic [22:0] B_COUT = 23'd1 << 16;
    localparam logic [22:0] B_BA   = 23'd1 << 17;
    localparam logic [22:0] B_ROUT = 23'd1 << 18;
    localparam logic [22:0] B_MDRO = 23'd1 << 19;
    localparam logic [22:0] B_ZLO  = 23'd1 << 20;
    localparam logic [22:0] B_PCO  = 23'd1 << 22;

    logic [22:0] got_vec;
    assign got_vec = {PCout, Zhighout, Zlowout, MDRout, Rout, BAout, Cout,
                      MARin, PCin, MDRin, IRin, Yin, Rin, ZLowIn, ZHighIn,
                      IncPC, Read, Write, Gra, Grb, Grc, run, illegal};

    int n_cmp = 0;
    int n_bad = 0;
    int m_count = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit is_rrr(input logic [4:0] op);
        return op == 5'b00011 || op == 5'b00100 || op == 5'b00101 || op == 5'b00110;
    endfunction
    function automatic bit is_imm(input logic [4:0] op);
        return op == 5'b01011 || op == 5'b01100 || op == 5'b01101;
    endfunction
    function automatic bit is_illegal(input logic [4:0] op);
        return !(is_rrr(op) || is_imm(op) || op == 5'b00000 || op == 5'b00001 ||
                 op == 5'b00010 || op == 5'b11010 || op == 5'b11011);
    endfunction

    function automatic int n_steps(input logic [4:0] op);
        if (op == 5'b00000 || op == 5'b00010) return 8;
        if (is_rrr(op) || is_imm(op) || op == 5'b00001) return 6;
        return 3;
    endfunction

    // Expected {strobes, alu opcode} for step k of the instruction with opcode op.
    function automatic logic [27:0] step_exp(input logic [4:0] op, input int k);
        logic [22:0] v;
        logic [4:0]  a;
        bit          st;
        v  = B_RUN;
        a  = 5'b00000;
        st = (op == 5'b00010);
        case (k)
            0: v |= B_PCO | B_MARI | B_INC | B_ZLI;
            1: v |= B_ZLO | B_PCIN | B_RD | B_MDRI;
            2: v |= B_MDRO | B_IRIN | (is_illegal(op) ? B_ILL : 23'd0);
            3: v |= B_GRB | B_YIN | ((is_rrr(op) || is_imm(op)) ? B_ROUT : B_BA);
            4: begin
                v |= B_ZLI;
                if (is_rrr(op)) begin
                    v |= B_GRC | B_ROUT; a = op;
                end else begin
                    v |= B_COUT;
                    a = (op == 5'b01100) ? 5'b00101 : (op == 5'b01101) ? 5'b00110 : 5'b00011;
                end
            end
            5: v |= (n_steps(op) == 8) ? (B_ZLO | B_MARI) : (B_ZLO | B_GRA | B_RIN);
            6: v |= st ? (B_GRA | B_ROUT | B_MDRI) : (B_RD | B_MDRI);
            default: v |= st ? B_WR : (B_MDRO | B_GRA | B_RIN);
        endcase
        return {v, a};
    endfunction

    task automatic check_idle(input string tag);
        check_eq({tag, " vec"}, 32'(got_vec), 32'd0);
        check_eq({tag, " opc"}, 32'(opcode), 32'd0);
        check_eq({tag, " cnt"}, 32'(instr_count), 32'(m_count));
    endtask

    // Run one instruction from T0; clr_at >= 0 asserts clear during that step.
    task automatic run_instr(input logic [31:0] irv, input int clr_at, output bit halted);
        logic [4:0]  op;
        logic [27:0] e;
        int          n;
        string       tag;
        op = irv[31:27];
        n = n_steps(op);
        halted = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            ir = irv;
            clear = (k == clr_at);
            #1;
            e = step_exp(op, k);
            tag = $sformatf("op%b k%0d", op, k);
            check_eq({tag, " vec"}, 32'(got_vec), 32'(e[27:5]));
            check_eq({tag, " opc"}, 32'(opcode), 32'(e[4:0]));
            check_eq({tag, " cnt"}, 32'(instr_count), 32'(m_count));
            if (k == clr_at) begin
                @(negedge clock);
                clear = 1'b0;
                m_count = 0;
                #1;
                check_idle($sformatf("op%b clr@%0d reset", op, k));
                return;
            end
        end
        if (!is_illegal(op))
            m_count = (m_count + 1) % (1 << CW);
        halted = (op == 5'b11011) || (is_illegal(op) && HOI != 0);
    endtask

    task automatic hold_and_clear(input int nc);
        for (int i = 0; i < nc; i++) begin
            @(negedge clock);
            #1;
            check_idle($sformatf("halted c%0d", i));
        end
        @(negedge clock);
        clear = 1'b1;
        #1;
        check_idle("halted clr");
        @(negedge clock);
        clear = 1'b0;
        m_count = 0;
        #1;
        check_idle("post-halt reset");
    endtask

    logic [4:0] legal_ops [12] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101,
                                  5'b00110, 5'b01011, 5'b01100, 5'b01101, 5'b11010, 5'b11011};

    initial begin
        bit          h;
        logic [31:0] rnd;
        logic [4:0]  op;
        int          ca;

        clear = 1'b1;
        ir = '0;
        @(negedge clock); #1; check_idle("reset c0");
        @(negedge clock); #1; check_idle("reset c1");
        @(negedge clock); clear = 1'b0; #1; check_idle("reset release");

        run_instr(32'h6A98_0003, -1, h);
        run_instr(32'h0080_1234, -1, h);
        run_instr(32'h1100_0040, -1, h);
        run_instr(32'h1888_0000, 4, h);
        run_instr(32'hF800_0000, -1, h);
        if (h) hold_and_clear(3);
        run_instr(32'hD800_0000, -1, h);
        if (h) hold_and_clear(20);

        // Enough back-to-back retirements to wrap the counter.
        for (int i = 0; i < 270; i++) begin
            run_instr(32'hD000_0000 | 32'(i), -1, h);
        end

        for (int i = 0; i < 300; i++) begin
            rnd = $urandom();
            if ($urandom_range(0, 15) < 12)
                op = legal_ops[$urandom_range(0, 11)];
            else
                op = 5'($urandom_range(0, 31));
            ca = ($urandom_range(0, 24) == 0) ? int'($urandom_range(0, n_steps(op) - 1)) : -1;
            run_instr({op, rnd[26:0]}, ca, h);
            if (h) hold_and_clear(int'($urandom_range(1, 4)));
        end

        @(negedge clock); #1;
        check_eq("final run", 32'(run), 32'd1);
        check_eq("final cnt", 32'(instr_count), 32'(m_count));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
